// File: rtl/s2p_framed_if.sv
// Parallel-side and serial-side signal bundle for the s2p_framed deserialiser.
// master: the deserialiser itself; slave: the serial source / parallel sink around it.
interface s2p_framed_if #(
    parameter int WIDTH = 8
);
    logic             load;
    logic             serin;
    logic [WIDTH-1:0] parout;
    logic             par_valid;
    logic             par_ready;
    logic             overrun;
    logic             parity_err;

    modport master (
        input  load, serin, par_ready,
        output parout, par_valid, overrun, parity_err
    );

    modport slave (
        output load, serin, par_ready,
        input  parout, par_valid, overrun, parity_err
    );
endinterface

// File: rtl/s2p_framed.sv
// Serial-to-parallel deserialiser with a registered valid/ready output and sticky overrun.
// Define S2P_FRAMED_PARITY_EN to consume a trailing even-parity bit per word.
module s2p_framed #(
    parameter int WIDTH     = 8,
    parameter bit LSB_FIRST = 1'b0
) (
    input  logic         clk,
    input  logic         rst,
    s2p_framed_if.master bus
);

`ifdef S2P_FRAMED_PARITY_EN
    localparam int FRAME = WIDTH + 1;
`else
    localparam int FRAME = WIDTH;
`endif
    localparam int CW = $clog2(FRAME);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    bcnt_q, bcnt_d;
    logic [WIDTH-1:0] shreg_q, shreg_shift, word;
    logic             done, shift_en;
    logic [WIDTH-1:0] parout_q;
    logic             valid_q, overrun_q;

    // Bit order is fixed at elaboration, so only one of these shifts survives synthesis.
    always_comb begin
        if (LSB_FIRST) shreg_shift = {bus.serin, shreg_q[WIDTH-1:1]};
        else           shreg_shift = {shreg_q[WIDTH-2:0], bus.serin};
    end

    // NOTE: every output of this block gets a default first so no latch is inferred on idle paths.
    always_comb begin
        state_d = state_q;
        bcnt_d  = bcnt_q;
        done    = 1'b0;
        if (bus.load) begin
            case (state_q)
                IDLE: begin
                    bcnt_d  = CW'(1);
                    state_d = SHIFT;
                end
                SHIFT: begin
                    if (bcnt_q == CW'(FRAME - 1)) begin
                        bcnt_d  = '0;
                        state_d = IDLE;
                        done    = 1'b1;
                    end else begin
                        bcnt_d = bcnt_q + CW'(1);
                    end
                end
                default: begin
                    bcnt_d  = '0;
                    state_d = IDLE;
                end
            endcase
        end
    end

`ifdef S2P_FRAMED_PARITY_EN
    // The parity bit is checked but never shifted, so the data word is already complete.
    logic perr_d, perr_q;
    assign shift_en = bus.load && (bcnt_q < CW'(WIDTH));
    assign word     = shreg_q;
    assign perr_d   = ^{shreg_q, bus.serin};
`else
    assign shift_en = bus.load;
    assign word     = shreg_shift;
`endif

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            bcnt_q  <= '0;
            shreg_q <= '0;
        end else begin
            state_q <= state_d;
            bcnt_q  <= bcnt_d;
            if (shift_en) shreg_q <= shreg_shift;
        end
    end

    // A completing word wins over a plain handshake; it is only dropped when the holder is stalled.
    always_ff @(posedge clk) begin
        if (rst) begin
            parout_q  <= '0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
`ifdef S2P_FRAMED_PARITY_EN
            perr_q    <= 1'b0;
`endif
        end else if (done) begin
            if (!valid_q || bus.par_ready) begin
                parout_q <= word;
                valid_q  <= 1'b1;
`ifdef S2P_FRAMED_PARITY_EN
                perr_q   <= perr_d;
`endif
            end else begin
                overrun_q <= 1'b1;
            end
        end else if (valid_q && bus.par_ready) begin
            valid_q <= 1'b0;
        end
    end

    assign bus.parout    = parout_q;
    assign bus.par_valid = valid_q;
    assign bus.overrun   = overrun_q;
`ifdef S2P_FRAMED_PARITY_EN
    assign bus.parity_err = perr_q;
`else
    assign bus.parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_s2p_framed.sv
// Self-checking bench for s2p_framed: directed vector table, corner sequences, random vs model.
// Two instances share stimulus so both bit orders are exercised together.
module tb_s2p_framed;
    localparam int WIDTH = 8;
`ifdef S2P_FRAMED_PARITY_EN
    localparam int FRAME = WIDTH + 1;
    localparam bit PAR   = 1'b1;
`else
    localparam int FRAME = WIDTH;
    localparam bit PAR   = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst, load, serin, par_ready;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    s2p_framed_if #(.WIDTH(WIDTH)) bus_m ();
    s2p_framed_if #(.WIDTH(WIDTH)) bus_l ();

    assign bus_m.load      = load;
    assign bus_m.serin     = serin;
    assign bus_m.par_ready = par_ready;
    assign bus_l.load      = load;
    assign bus_l.serin     = serin;
    assign bus_l.par_ready = par_ready;

    s2p_framed #(.WIDTH(WIDTH), .LSB_FIRST(1'b0)) dut_m (.clk(clk), .rst(rst), .bus(bus_m.master));
    s2p_framed #(.WIDTH(WIDTH), .LSB_FIRST(1'b1)) dut_l (.clk(clk), .rst(rst), .bus(bus_l.master));

    typedef struct {
        logic [7:0] pat;
        logic [7:0] exp_m;
        logic [7:0] exp_l;
    } vec_t;

    vec_t vecs [7];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Sends pat first-bit = pat[7]; par_ready is rdy_base except on the frame's last edge.
    task automatic send_word(input logic [7:0] pat, input logic pbit,
                             input logic rdy_last, input logic rdy_base);
        for (int i = WIDTH - 1; i >= 0; i--) begin
            load      = 1'b1;
            serin     = pat[i];
            par_ready = (i == 0 && !PAR) ? rdy_last : rdy_base;
            step();
        end
        if (PAR) begin
            serin     = pbit;
            par_ready = rdy_last;
            step();
        end
        load      = 1'b0;
        par_ready = rdy_base;
    endtask

    // Reference model: collect raw bits per frame and assemble words arithmetically.
    logic       m_bits [$];
    logic [7:0] m_par_m, m_par_l;
    logic       m_valid, m_ovr, m_perr;

    task automatic model_edge(input logic r, input logic ld, input logic s, input logic rdy);
        logic       complete;
        logic [7:0] wm, wl;
        logic       pe;
        if (r) begin
            m_bits.delete();
            m_par_m = '0; m_par_l = '0;
            m_valid = 1'b0; m_ovr = 1'b0; m_perr = 1'b0;
            return;
        end
        complete = 1'b0;
        wm = '0; wl = '0; pe = 1'b0;
        if (ld) begin
            m_bits.push_back(s);
            if (m_bits.size() == FRAME) begin
                complete = 1'b1;
                for (int i = 0; i < WIDTH; i++) begin
                    wm = wm | (8'(m_bits[i]) << (WIDTH - 1 - i));
                    wl = wl | (8'(m_bits[i]) << i);
                end
                if (PAR) for (int i = 0; i < FRAME; i++) pe = pe ^ m_bits[i];
                m_bits.delete();
            end
        end
        if (complete) begin
            if (!m_valid || rdy) begin
                m_par_m = wm; m_par_l = wl; m_valid = 1'b1; m_perr = pe;
            end else begin
                m_ovr = 1'b1;
            end
        end else if (m_valid && rdy) begin
            m_valid = 1'b0;
        end
    endtask

    initial begin
        vecs[0] = '{8'hAE, 8'hAE, 8'h75};
        vecs[1] = '{8'h3C, 8'h3C, 8'h3C};
        vecs[2] = '{8'h01, 8'h01, 8'h80};
        vecs[3] = '{8'hF0, 8'hF0, 8'h0F};
        vecs[4] = '{8'hFF, 8'hFF, 8'hFF};
        vecs[5] = '{8'h00, 8'h00, 8'h00};
        vecs[6] = '{8'hC5, 8'hC5, 8'hA3};

        // Reset with load high and serin toggling must leave nothing behind.
        rst = 1'b1; load = 1'b1; par_ready = 1'b1; serin = 1'b0;
        for (int i = 0; i < 2; i++) begin
            serin = ~serin;
            step();
        end
        check("rst_parout_m", bus_m.parout, 8'h00);
        check("rst_parout_l", bus_l.parout, 8'h00);
        check("rst_valid", {bus_m.par_valid, bus_l.par_valid}, 2'b00);
        check("rst_overrun", {bus_m.overrun, bus_l.overrun}, 2'b00);
        check("rst_perr", {bus_m.parity_err, bus_l.parity_err}, 2'b00);
        rst = 1'b0; load = 1'b0;
        step();

        // Directed table: one word per entry, valid for exactly one cycle with ready high.
        for (int v = 0; v < 7; v++) begin
            send_word(vecs[v].pat, ^vecs[v].pat, 1'b1, 1'b1);
            check($sformatf("tbl%0d_parout_m", v), bus_m.parout, vecs[v].exp_m);
            check($sformatf("tbl%0d_parout_l", v), bus_l.parout, vecs[v].exp_l);
            check($sformatf("tbl%0d_valid", v), {bus_m.par_valid, bus_l.par_valid}, 2'b11);
            check($sformatf("tbl%0d_perr", v), {bus_m.parity_err, bus_l.parity_err}, 2'b00);
            step();
            check($sformatf("tbl%0d_valid_drop", v), {bus_m.par_valid, bus_l.par_valid}, 2'b00);
        end

        // Pause after four bits, then resume: the partial word survives idling.
        par_ready = 1'b1;
        for (int i = 7; i >= 4; i--) begin
            load = 1'b1; serin = vecs[0].pat[i]; step();
        end
        load = 1'b0;
        for (int i = 0; i < 5; i++) step();
        check("pause_valid_idle", bus_m.par_valid, 1'b0);
        for (int i = 3; i >= 0; i--) begin
            load = 1'b1; serin = vecs[0].pat[i]; step();
        end
        if (PAR) begin
            check("pause_valid_pre_par", bus_m.par_valid, 1'b0);
            serin = ^vecs[0].pat; step();
        end
        load = 1'b0;
        check("pause_parout_m", bus_m.parout, 8'hAE);
        check("pause_parout_l", bus_l.parout, 8'h75);
        check("pause_valid", bus_m.par_valid, 1'b1);
        step();

        // Back-pressure: second word dropped, overrun sticky until reset.
        send_word(8'hAE, 1'b1, 1'b0, 1'b0);
        check("bp_first_valid", bus_m.par_valid, 1'b1);
        send_word(8'h3C, 1'b0, 1'b0, 1'b0);
        check("bp_parout_m", bus_m.parout, 8'hAE);
        check("bp_overrun", {bus_m.overrun, bus_l.overrun}, 2'b11);
        check("bp_valid_held", bus_m.par_valid, 1'b1);
        par_ready = 1'b1; step();
        check("bp_valid_drop", bus_m.par_valid, 1'b0);
        check("bp_overrun_sticky", bus_m.overrun, 1'b1);
        step();
        check("bp_overrun_sticky2", bus_l.overrun, 1'b1);
        rst = 1'b1; step(); rst = 1'b0;
        check("bp_overrun_rst", {bus_m.overrun, bus_l.overrun}, 2'b00);

        // Accept on the same edge as a new completion: no bubble, no overrun.
        send_word(8'hAE, 1'b1, 1'b0, 1'b0);
        send_word(8'h3C, 1'b0, 1'b1, 1'b0);
        check("sim_parout_m", bus_m.parout, 8'h3C);
        check("sim_parout_l", bus_l.parout, 8'h3C);
        check("sim_valid", bus_m.par_valid, 1'b1);
        check("sim_overrun", bus_m.overrun, 1'b0);
        par_ready = 1'b1; step();
        check("sim_valid_drop", bus_m.par_valid, 1'b0);

`ifdef S2P_FRAMED_PARITY_EN
        send_word(8'hAE, 1'b1, 1'b1, 1'b1);
        check("par_ok_perr", {bus_m.parity_err, bus_l.parity_err}, 2'b00);
        check("par_ok_parout", bus_m.parout, 8'hAE);
        step();
        send_word(8'hAE, 1'b0, 1'b1, 1'b1);
        check("par_bad_perr", {bus_m.parity_err, bus_l.parity_err}, 2'b11);
        check("par_bad_parout_m", bus_m.parout, 8'hAE);
        check("par_bad_parout_l", bus_l.parout, 8'h75);
        step();
`endif

        // Random traffic against the reference model.
        rst = 1'b1; load = 1'b0; serin = 1'b0; par_ready = 1'b0;
        model_edge(1'b1, 1'b0, 1'b0, 1'b0);
        step();
        for (int c = 0; c < 3000; c++) begin
            rst       = ($urandom_range(0, 199) == 0);
            load      = ($urandom_range(0, 3) != 0);
            serin     = 1'($urandom_range(0, 1));
            par_ready = ($urandom_range(0, 2) != 0);
            model_edge(rst, load, serin, par_ready);
            step();
            check($sformatf("rand%0d", c),
                  {bus_m.parout, bus_l.parout, bus_m.par_valid, bus_l.par_valid,
                   bus_m.overrun, bus_l.overrun, bus_m.parity_err, bus_l.parity_err},
                  {m_par_m, m_par_l, m_valid, m_valid, m_ovr, m_ovr, m_perr, m_perr});
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/s2p_framed.md
# s2p_framed

Parametrised serial-to-parallel deserialiser, successor to the fixed 8-bit `s2p` converter. It shifts in one bit per enabled clock and assembles words of configurable width in either bit order. Each completed word is held in an output register and offered downstream with a valid/ready handshake; an overrun flag reports any word lost to back-pressure. It sits between a serial link front-end and the parallel datapath, in the data_converter group.

## Interface
- `WIDTH`, 8, data word width in bits (≥2).
- `LSB_FIRST`, 0, bit order: 0 = first received bit lands in `parout[WIDTH-1]` (MSB first); 1 = first bit lands in `parout[0]`.
- `clk`  input  1  clock; all logic on the rising edge.
- `rst`  input  1  reset, synchronous and active-high.
- `load`  input  1  shift enable; `serin` is sampled on each rising edge where `load`=1.
- `serin`  input  1  serial data bit.
- `parout`  output  WIDTH  last completed word, registered.
- `par_valid`  output  1  `parout` holds a word not yet accepted.
- `par_ready`  input  1  downstream accepts `parout` when `par_valid`=1 and `par_ready`=1 on the same edge.
- `overrun`  output  1  sticky: a completed word was dropped.
- `parity_err`  output  1  parity result for the word in `parout` (see Configuration).

## Operation
- Internal shift register `shreg` (WIDTH bits) and bit counter `bcnt`. Counter width is $clog2(FRAME), where FRAME = WIDTH, or WIDTH+1 with parity enabled.
- FSM states:
  - IDLE: `bcnt`=0.
  - SHIFT: 0 < `bcnt` < FRAME.
  - Transitions advance only on edges with `load`=1.
- `load`=0 pauses the frame. `bcnt` and `shreg` hold; a partial word is never discarded by idling.
- MSB-first order: `shreg <= {shreg[WIDTH-2:0], serin}`.
- LSB-first order: `shreg <= {serin, shreg[WIDTH-1:1]}`.
- Frame completion occurs on the edge sampling bit FRAME-1. On that edge:
  - `bcnt` returns to 0.
  - The assembled word, including the bit sampled on that edge, is offered to the output register.
- Output register update on a completion edge:
  - `par_valid`=0: load `parout`, set `par_valid`=1.
  - `par_valid`=1 and `par_ready`=1 (accept on the same edge): load the new word and keep `par_valid`=1. There is no bubble and no overrun.
  - `par_valid`=1 and `par_ready`=0: the new word is dropped, `parout` is unchanged, and `overrun` is set.
- On any non-completion edge, a handshake (`par_valid` & `par_ready`) clears `par_valid`. `parout` keeps its last value.
- `overrun` is cleared only by `rst`.
- Reset (`rst`=1 on an edge) overrides `load` and any handshake. Reset values:
  - `bcnt`=0, `shreg`=0.
  - `parout`=0, `par_valid`=0, `overrun`=0, `parity_err`=0.
  - A frame in progress is abandoned.

## Timing
- Latency: a word is visible on `parout`/`par_valid` in the cycle after the edge that samples its last bit (data bit, or parity bit with parity enabled).
- Sustained throughput: one word per FRAME enabled cycles.
- Back-to-back words with `load` held high create no gap cycles.
- `par_ready` is sampled only when `par_valid`=1; its value while `par_valid`=0 is ignored.
- All outputs come directly from registers; there is no combinational path from input to output.

## Configuration
- Macro `S2P_FRAMED_PARITY_EN`.
- Defined:
  - FRAME = WIDTH+1. The bit after the data bits is an even-parity bit: XOR of all data bits and the parity bit must be 0.
  - `parity_err` is loaded together with `parout` and is 1 if the check fails.
  - A dropped word does not update `parity_err`.
- Undefined:
  - FRAME = WIDTH; no parity bit is consumed.
  - `parity_err` is tied to 0.

## Test plan
- Reset: hold `rst`=1 for 2 cycles with `load`=1 and `serin` toggling -> `parout`=0, `par_valid`=0, `overrun`=0. The next frame starts from bit 0.
- MSB-first capture: WIDTH=8, LSB_FIRST=0, `par_ready`=1, stream 1,0,1,0,1,1,1,0 -> `parout`=8'hAE, `par_valid` high for exactly 1 cycle after the 8th edge. Repeat with LSB_FIRST=1 -> `parout`=8'h75.
- Pause: deassert `load` for 5 cycles after bit 3 of the 8'hAE stream, then resume -> `parout`=8'hAE. `par_valid` rises only after the 8th enabled edge.
- Back-pressure:
  - Hold `par_ready`=0 across two full frames 8'hAE then 8'h3C -> `parout` stays 8'hAE and `overrun`=1.
  - Raise `par_ready` -> `par_valid` drops; `overrun` stays 1 until `rst`.
- Simultaneous events: `par_ready` asserted on the same edge that completes a second frame 8'h3C -> `parout`=8'h3C, `par_valid` stays 1, `overrun`=0.
- Parity (macro defined): 8'hAE followed by parity bit 1 -> `parity_err`=0. 8'hAE followed by parity bit 0 -> `parity_err`=1. The 9th bit is not shifted into `parout`.
